dmem_responder: RTL and testbench

Data-memory responder for the 8-bit pipelined processor. It serves the load/store strobes raised by the execute-stage control (MemRead for loads, MemWrite for stores) against an internal byte-wide array. It inserts a configurable number of wait states and freezes the pipeline with `stall` until each access retires. On read completion it returns the data with a one-cycle valid strobe that drives the MDR load.

---
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: byte array with configurable wait states, pipeline stall and MDR strobe.
// Optional DMEM_POSTED_WRITE_EN adds a one-entry posted-write buffer so stores do not stall.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              busy,
  output logic              protocol_err
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              protocol_err_q, protocol_err_d;

  logic [DATA_W-1:0] mem_q [Depth];

  logic              request, accept, post, fsm_start;
  logic              buf_valid, buf_drain;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign request   = mem_read | mem_write;
  // A pending posted write holds off every new request until it drains.
  assign accept    = (state_q == StIdle) && request && !buf_valid;
  assign fsm_start = accept && !post;

`ifdef DMEM_POSTED_WRITE_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [3:0]        buf_cnt_q, buf_cnt_d;

  assign post      = (state_q == StIdle) && mem_write && !buf_valid_q;
  assign buf_drain = buf_valid_q && (buf_cnt_q == 4'd0);

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_cnt_d   = buf_cnt_q;
    if (post) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = addr;
      buf_data_d  = wdata;
      buf_cnt_d   = WaitCnt;
    end else if (buf_valid_q) begin
      if (buf_cnt_q == 4'd0) begin
        buf_valid_d = 1'b0;
      end else begin
        buf_cnt_d = buf_cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_cnt_q   <= 4'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_cnt_q   <= buf_cnt_d;
    end
  end

  assign buf_valid = buf_valid_q;
  assign buf_addr  = buf_addr_q;
  assign buf_data  = buf_data_q;
`else
  assign post      = 1'b0;
  assign buf_drain = 1'b0;
  assign buf_valid = 1'b0;
  assign buf_addr  = '0;
  assign buf_data  = '0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    is_write_d     = is_write_q;
    rdata_d        = rdata_q;
    rdata_valid_d  = 1'b0;
    protocol_err_d = accept && mem_read && mem_write;
    rd_addr        = addr_q;
    unique case (state_q)
      StIdle: begin
        if (fsm_start) begin
          addr_d     = addr;
          wdata_d    = wdata;
          is_write_d = mem_write;
          cnt_d      = WaitCnt;
          rd_addr    = addr;
          if (WaitCnt == 4'd0) begin
            state_d       = StDone;
            rdata_valid_d = !mem_write;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d       = StDone;
          rdata_valid_d = !is_write_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Read data is captured on the edge entering DONE so it is registered during DONE.
    if (rdata_valid_d) begin
      rdata_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      addr_q         <= '0;
      wdata_q        <= '0;
      is_write_q     <= 1'b0;
      rdata_q        <= '0;
      rdata_valid_q  <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      is_write_q     <= is_write_d;
      rdata_q        <= rdata_d;
      rdata_valid_q  <= rdata_valid_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign mem_we    = !reset && (buf_drain || ((state_q == StDone) && is_write_q));
  assign mem_waddr = buf_drain ? buf_addr : addr_q;
  assign mem_wdata = buf_drain ? buf_data : wdata_q;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign stall        = ((state_q == StIdle) && request && !post) || (state_q == StWait);
  assign busy         = (state_q != StIdle) || buf_valid;
  assign rdata        = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: index 0 is a WAIT_STATES=0 instance, index 1 uses WAIT_STATES=2.
module tb_dmem_responder;

  logic       clock = 1'b0;
  logic       reset        [2];
  logic       mem_read     [2];
  logic       mem_write    [2];
  logic [7:0] addr         [2];
  logic [7:0] wdata        [2];
  logic [7:0] rdata        [2];
  logic       rdata_valid  [2];
  logic       stall        [2];
  logic       busy         [2];
  logic       protocol_err [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]),
    .stall(stall[0]), .busy(busy[0]), .protocol_err(protocol_err[0])
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(2)) u_ws2 (
    .clock(clock), .reset(reset[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]),
    .stall(stall[1]), .busy(busy[1]), .protocol_err(protocol_err[1])
  );

  function automatic void check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  typedef struct {
    int         d;
    bit         rd;
    bit         wr;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    string      nm;
  } vec_t;

  // One complete access; returns the cycle number of the rdata_valid pulse (-1 if none).
  task automatic access(input int d, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input string nm,
                        output int vcyc);
    int         ws;
    int         hold;
    bit         posted;
    logic [7:0] got;
    ws     = (d == 1) ? 2 : 0;
    posted = 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
    posted = wr;
`endif
    hold   = posted ? 1 : ws + 2;
    got    = 8'h00;
    vcyc   = -1;
    mem_read[d]  = rd;
    mem_write[d] = wr;
    addr[d]      = a;
    wdata[d]     = wd;
    for (int k = 0; k < ws + 2; k++) begin
      @(negedge clock);
      check($sformatf("%s stall@%0d", nm, k), int'(stall[d]),
            int'(!posted && (k <= ws)));
      check($sformatf("%s valid@%0d", nm, k), int'(rdata_valid[d]),
            int'(rd && !wr && (k == ws + 1)));
      check($sformatf("%s perr@%0d", nm, k), int'(protocol_err[d]),
            int'(rd && wr && (k == 1)));
      if (rdata_valid[d]) begin
        got  = rdata[d];
        vcyc = cyc;
      end
      @(posedge clock);
      #1;
      if (k == hold - 1) begin
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
      end
    end
    if (rd && !wr) check({nm, " rdata"}, int'(got), int'(exp_rd));
    check({nm, " busy_end"}, int'(busy[d]), 0);
  endtask

  task automatic check_idle_outputs(input int d, input string nm);
    check({nm, " stall"}, int'(stall[d]), 0);
    check({nm, " busy"}, int'(busy[d]), 0);
    check({nm, " valid"}, int'(rdata_valid[d]), 0);
    check({nm, " rdata"}, int'(rdata[d]), 0);
    check({nm, " perr"}, int'(protocol_err[d]), 0);
  endtask

  initial begin
    vec_t vecs [11];
    int   v1;
    int   v2;
    int   lat;
    bit   seen;
    logic [7:0] got;

    vecs[0]  = '{1, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, "w10"};
    vecs[1]  = '{1, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, "r10"};
    vecs[2]  = '{0, 1'b0, 1'b1, 8'h3F, 8'h5C, 8'h00, "ws0_w3f"};
    vecs[3]  = '{0, 1'b1, 1'b0, 8'h3F, 8'h00, 8'h5C, "ws0_r3f"};
    vecs[4]  = '{1, 1'b1, 1'b1, 8'h20, 8'h11, 8'h00, "both20"};
    vecs[5]  = '{1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h11, "r20"};
    vecs[6]  = '{1, 1'b0, 1'b1, 8'hFF, 8'hC3, 8'h00, "wff"};
    vecs[7]  = '{1, 1'b0, 1'b1, 8'h00, 8'h3A, 8'h00, "w00"};
    vecs[8]  = '{0, 1'b1, 1'b1, 8'h01, 8'h99, 8'h00, "ws0_both01"};
    vecs[9]  = '{0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h99, "ws0_r01"};
    vecs[10] = '{1, 1'b0, 1'b1, 8'h40, 8'h12, 8'h00, "w40_pre"};

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
      addr[d] = 8'h00; wdata[d] = 8'h00;
    end
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    foreach (vecs[i]) begin
      access(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].exp_rd,
             vecs[i].nm, v1);
    end

    // Back-to-back reads: pulses exactly WAIT_STATES+2 cycles apart.
    access(1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3, "b2b_rff", v1);
    access(1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3A, "b2b_r00", v2);
    check("b2b spacing", v2 - v1, 4);

    // Reset during WAIT aborts the write to 0x40.
    mem_write[1] = 1'b1; addr[1] = 8'h40; wdata[1] = 8'h77;
    @(posedge clock);
    #1;
    reset[1] = 1'b1;
    mem_write[1] = 1'b0;
    @(posedge clock);
    #1;
    check_idle_outputs(1, "midreset");
    reset[1] = 1'b0;
    access(1, 1'b1, 1'b0, 8'h40, 8'h00, 8'h12, "r40_after_rst", v1);

`ifdef DMEM_POSTED_WRITE_EN
    // Posted write, then an immediate read that must wait for the drain.
    mem_write[1] = 1'b1; addr[1] = 8'h08; wdata[1] = 8'h3C;
    @(negedge clock);
    check("posted w stall", int'(stall[1]), 0);
    @(posedge clock);
    #1;
    mem_write[1] = 1'b0;
    mem_read[1]  = 1'b1;
    @(negedge clock);
    check("posted r stall", int'(stall[1]), 1);
    @(posedge clock);
    #1;
    lat  = 1;
    seen = 1'b0;
    got  = 8'h00;
    while (!seen && lat < 20) begin
      @(negedge clock);
      if (rdata_valid[1]) begin
        seen = 1'b1;
        got  = rdata[1];
      end else begin
        lat++;
      end
      @(posedge clock);
      #1;
    end
    mem_read[1] = 1'b0;
    check("posted r seen", int'(seen), 1);
    check("posted r latency", lat, 6);
    check("posted r data", int'(got), 8'h3C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
